// File: rtl/test_pkg.sv
// test_pkg: shared state encoding, result polarity and index-width helper
// for the self-test monitor.
package test_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;
  localparam logic RESULT_FAIL = 1'b1;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/test_monitor_prio_enc.sv
// prio_enc: lowest-set-bit priority encoder.
// Ports: req (N request bits), idx (index of lowest set bit, 0 if none),
//        valid (any request bit set).
module prio_enc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/test_monitor.sv
// test_monitor: reduces per-unit self-test done/result signals to a single
// sticky verdict with first-failure index, cycle count and timeout watchdog.
// Ports: clk, rst_n (async active-low); start begins a run from any non-RUN
//        state; test_done/test_result per unit (result 1 = failure);
//        running/all_done/timeout state flags; any_fail, fail_mask sticky
//        failures; first_fail_valid/first_fail_idx first failing unit;
//        cycle_count saturating RUN cycles; finish one-cycle end pulse.
module test_monitor
  import test_pkg::*;
#(
  parameter int NUM_TESTS      = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CYCLE_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_TESTS-1:0]          test_done,
  input  logic [NUM_TESTS-1:0]          test_result,
  output logic                          running,
  output logic                          all_done,
  output logic                          timeout,
  output logic                          any_fail,
  output logic [NUM_TESTS-1:0]          fail_mask,
  output logic                          first_fail_valid,
  output logic [idx_w(NUM_TESTS)-1:0]   first_fail_idx,
  output logic [CYCLE_W-1:0]            cycle_count,
  output logic                          finish
);
  localparam int IDX_W = idx_w(NUM_TESTS);
  localparam logic [CYCLE_W:0] TO_LIM = (CYCLE_W + 1)'(TIMEOUT_CYCLES);
  state_t               state;
  logic [NUM_TESTS-1:0] done_seen;
  logic [NUM_TESTS-1:0] new_fail;
  logic [NUM_TESTS-1:0] new_done;
  logic [CYCLE_W:0]     cnt_inc;
  logic [CYCLE_W-1:0]   cnt_sat;
  logic                 all_now;
  logic                 to_hit;
  logic [IDX_W-1:0]     pe_idx;
  logic                 pe_valid;
  // Units that already reported done are masked so late glitches are ignored.
  assign new_fail = ~done_seen & ~(test_result ^ {NUM_TESTS{RESULT_FAIL}});
  assign new_done = ~done_seen & test_done;
  assign all_now  = &(done_seen | new_done);
  // cnt_inc is the count including the current RUN cycle; its carry marks saturation.
  assign cnt_inc  = {1'b0, cycle_count} + {{CYCLE_W{1'b0}}, 1'b1};
  assign cnt_sat  = cnt_inc[CYCLE_W] ? cycle_count : cnt_inc[CYCLE_W-1:0];
  assign to_hit   = cnt_inc >= TO_LIM;
  assign any_fail = |fail_mask;
  prio_enc #(.N(NUM_TESTS), .W(IDX_W)) u_pe (
    .req  (new_fail),
    .idx  (pe_idx),
    .valid(pe_valid)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      running          <= 1'b0;
      all_done         <= 1'b0;
      timeout          <= 1'b0;
      fail_mask        <= '0;
      done_seen        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      cycle_count      <= '0;
      finish           <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (state == ST_RUN) begin
        fail_mask   <= fail_mask | new_fail;
        done_seen   <= done_seen | new_done;
        cycle_count <= cnt_sat;
        if (!first_fail_valid && pe_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= pe_idx;
        end
        if (all_now) begin
          state    <= ST_DONE;
          running  <= 1'b0;
          all_done <= 1'b1;
          finish   <= 1'b1;
        end else if (to_hit) begin
          state   <= ST_TIMEOUT;
          running <= 1'b0;
          timeout <= 1'b1;
          finish  <= 1'b1;
        end
      end else if (start) begin
        state            <= ST_RUN;
        running          <= 1'b1;
        all_done         <= 1'b0;
        timeout          <= 1'b0;
        fail_mask        <= '0;
        done_seen        <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
        cycle_count      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed self-checking bench for test_monitor
// (NUM_TESTS=2, TIMEOUT_CYCLES=16, CYCLE_W=8).
module tb_test_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] test_done = 2'b00;
  logic [1:0] test_result = 2'b00;
  logic       running, all_done, timeout, any_fail, first_fail_valid, finish;
  logic [1:0] fail_mask;
  logic [0:0] first_fail_idx;
  logic [7:0] cycle_count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  test_monitor #(.NUM_TESTS(2), .TIMEOUT_CYCLES(16), .CYCLE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done),
    .test_result(test_result), .running(running), .all_done(all_done),
    .timeout(timeout), .any_fail(any_fail), .fail_mask(fail_mask),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .cycle_count(cycle_count), .finish(finish)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".outs"}, {running, all_done, timeout, any_fail, fail_mask,
                         first_fail_valid, first_fail_idx, finish}, 0);
    chk({tag, ".cnt"}, cycle_count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_running", running, 0);
    // T1: clean pass, both done on cycle 5
    go();
    chk("t1_running", running, 1);
    chk("t1_cnt0", cycle_count, 0);
    tick(4);
    chk("t1_cnt4", cycle_count, 4);
    test_done = 2'b11;
    tick();
    test_done = 2'b00;
    chk("t1_finish", finish, 1);
    chk("t1_all_done", all_done, 1);
    chk("t1_running_off", running, 0);
    chk("t1_any_fail", any_fail, 0);
    chk("t1_mask", fail_mask, 2'b00);
    chk("t1_cnt", cycle_count, 5);
    tick();
    chk("t1_finish_once", finish, 0);
    chk("t1_done_hold", all_done, 1);
    chk("t1_cnt_hold", cycle_count, 5);
    // T2: unit1 fails on cycle 3, both done on cycle 6
    go();
    chk("t2_all_done_fall", all_done, 0);
    chk("t2_cnt_clear", cycle_count, 0);
    tick(2);
    test_result = 2'b10;
    tick();
    chk("t2_ffv", first_fail_valid, 1);
    chk("t2_ffi", first_fail_idx, 1);
    tick(2);
    test_done = 2'b11;
    tick();
    test_done = 2'b00;
    test_result = 2'b00;
    chk("t2_mask", fail_mask, 2'b10);
    chk("t2_any_fail", any_fail, 1);
    chk("t2_ffi_end", first_fail_idx, 1);
    chk("t2_all_done", all_done, 1);
    // T2b: unit1 fails first, unit0 later -> idx stays 1
    go();
    chk("t2b_mask_clear", fail_mask, 2'b00);
    chk("t2b_ffv_clear", first_fail_valid, 0);
    test_result = 2'b10;
    tick();
    test_result = 2'b01;
    tick();
    test_result = 2'b00;
    test_done = 2'b11;
    tick();
    test_done = 2'b00;
    chk("t2b_mask", fail_mask, 2'b11);
    chk("t2b_ffi", first_fail_idx, 1);
    // T3: both fail on cycle 4 -> lowest index wins; done on cycle 7
    go();
    tick(3);
    test_result = 2'b11;
    tick();
    test_result = 2'b00;
    chk("t3_ffi", first_fail_idx, 0);
    chk("t3_mask", fail_mask, 2'b11);
    tick();
    test_result = 2'b01;
    tick();
    test_result = 2'b00;
    test_done = 2'b11;
    tick();
    test_done = 2'b00;
    chk("t3_ffi_end", first_fail_idx, 0);
    chk("t3_all_done", all_done, 1);
    // T4: unit0 done pulse cycle 2, late result ignored, unit1 never done
    go();
    tick();
    test_done = 2'b01;
    tick();
    test_done = 2'b00;
    tick(2);
    test_result = 2'b01;
    tick(11);
    chk("t4_pre_timeout", timeout, 0);
    chk("t4_pre_cnt", cycle_count, 15);
    chk("t4_pre_running", running, 1);
    tick();
    test_result = 2'b00;
    chk("t4_timeout", timeout, 1);
    chk("t4_finish", finish, 1);
    chk("t4_all_done", all_done, 0);
    chk("t4_mask", fail_mask, 2'b00);
    chk("t4_cnt", cycle_count, 16);
    tick();
    chk("t4_finish_once", finish, 0);
    chk("t4_cnt_hold", cycle_count, 16);
    // T5: final done on cycle 16 beats timeout
    go();
    chk("t5_timeout_fall", timeout, 0);
    test_done = 2'b01;
    tick();
    test_done = 2'b00;
    tick(14);
    test_done = 2'b10;
    tick();
    test_done = 2'b00;
    chk("t5_all_done", all_done, 1);
    chk("t5_timeout", timeout, 0);
    chk("t5_finish", finish, 1);
    chk("t5_cnt", cycle_count, 16);
    // T6: reset mid-RUN on cycle 3, no finish afterwards
    go();
    test_result = 2'b01;
    tick(2);
    chk("t6_pre_mask", fail_mask, 2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_reset");
    test_result = 2'b00;
    tick();
    chk("t6_no_finish", finish, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle", running, 0);
    // re-run from DONE after a failing run clears the record
    go();
    test_result = 2'b01;
    test_done = 2'b11;
    tick();
    test_result = 2'b00;
    test_done = 2'b00;
    chk("t6_done_mask", fail_mask, 2'b01);
    go();
    chk("t6_rerun_mask", fail_mask, 2'b00);
    chk("t6_rerun_cnt", cycle_count, 0);
    chk("t6_rerun_running", running, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/test_monitor.md
Name: test_monitor

Overview:
- Consumes the per-unit self-test outputs (done, result) of N test units on the FPGA bench and reduces them to one verdict.
- Provides a sticky pass/fail record, the first failing unit, a cycle count and a timeout watchdog.
- Emits a one-cycle finish pulse that ends simulation, and drives status LEDs on hardware.

Parameters:
- NUM_TESTS, 2, number of test units monitored (>=1).
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before declaring timeout (>=2).
- CYCLE_W, 16, width of cycle counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level/pulse; begins a run when sampled high in IDLE, DONE or TIMEOUT.
- test_done  in  NUM_TESTS  per-unit done; may be level or single-cycle pulse.
- test_result  in  NUM_TESTS  per-unit result; 1 = failure.
- running  out  1  high in RUN.
- all_done  out  1  high in DONE.
- timeout  out  1  high in TIMEOUT.
- any_fail  out  1  OR of fail_mask.
- fail_mask  out  NUM_TESTS  sticky per-unit failure.
- first_fail_valid  out  1  a failure has been recorded this run.
- first_fail_idx  out  IDX_W  index of first failing unit; IDX_W = max(1, clog2(NUM_TESTS)).
- cycle_count  out  CYCLE_W  RUN cycles elapsed, saturating at all-ones.
- finish  out  1  one-cycle pulse on entry to DONE or TIMEOUT.

Behaviour:
- Reset (async assert, sync-release use of clk): state IDLE; every output 0; internal done_seen mask 0.
- States: IDLE, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start=1 -> RUN next cycle. On that same edge:
  - clear fail_mask, done_seen, first_fail_*, cycle_count.
  - drive finish=0.
  - DONE/TIMEOUT outputs fall.
- start while in RUN is ignored.
- In RUN, each cycle, per unit i with done_seen[i]=0:
  - if test_result[i]=1, set fail_mask[i].
  - if test_done[i]=1, set done_seen[i]; result is sampled in the same cycle as done.
  - Units with done_seen[i]=1 are ignored thereafter (late result glitches are not recorded).
- first_fail:
  - Set on the first RUN cycle in which any fail_mask bit newly sets.
  - If several set in that cycle, the lowest index wins.
  - Never overwritten within a run.
- cycle_count:
  - Increments on every RUN cycle including the exit cycle; holds outside RUN.
  - Saturates, no wrap.
  - First RUN cycle is counted as 1 (value visible the cycle after).
- Exit to DONE:
  - Occurs when (done_seen | new done) is all-ones at a clock edge.
  - Takes priority over timeout in the same cycle.
- Exit to TIMEOUT:
  - Occurs when the cycle count including the current cycle reaches TIMEOUT_CYCLES and not all done.
  - timeout=1 and any_fail is left as recorded; unfinished units are not marked failed.
- finish: registered, high exactly the first cycle in DONE or TIMEOUT.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0; no finish pulse.
- test_done/test_result are assumed synchronous to clk; no synchroniser inside.

Decomposition:
- Shared package test_pkg:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_DONE=2, ST_TIMEOUT=3.
  - RESULT_FAIL=1'b1.
  - IDX_W function (clog2 with minimum 1).
- One natural sub-module: prio_enc, a lowest-set-bit priority encoder NUM_TESTS -> IDX_W plus valid. Used for first_fail_idx and reusable elsewhere.

Test Plan (NUM_TESTS=2, TIMEOUT_CYCLES=16, CYCLE_W=8):
- Reset, start pulse; test_done=11 on RUN cycle 5, test_result=00 -> finish one cycle; all_done=1, any_fail=0, fail_mask=00, cycle_count=5.
- Unit1 result=1 at cycle 3, done both at cycle 6 -> fail_mask=10, first_fail_valid=1, first_fail_idx=1, any_fail=1, all_done=1.
- Both results rise same cycle 4, done cycle 7 -> first_fail_idx=0, fail_mask=11; a later unit0 fail does not change idx.
- Unit0 done at cycle 2 (pulse), result0 goes high at cycle 5, unit1 never done -> TIMEOUT after cycle 16; timeout=1, fail_mask=00, cycle_count=16, finish pulses once.
- Final done arrives on cycle 16 -> DONE, not TIMEOUT; all_done=1, timeout=0.
- rst_n low at cycle 3 of RUN -> all outputs 0 immediately, no finish. Start from DONE re-runs with cleared fail_mask and cycle_count=0.
